// File: rtl/fhe_op_sequencer.sv
// Queues homomorphic operations from the host and issues them one at a time to the cpu op port,
// with a writeback settle cycle after each completion and a sticky completion-timeout error.
module fhe_op_sequencer #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 500,
    parameter int CNT_W       = 16,
    localparam int OP_W       = 34,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    output logic             in_ready,
    input  logic             flush,
    input  logic             clear_err,
    output logic [OP_W-1:0]  cpu_op,
    input  logic             cpu_done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [3:0] NO_OP = 4'd0;

    typedef struct packed {
        logic [3:0] mode;
        logic [4:0] idx1_a;
        logic [4:0] idx1_b;
        logic [4:0] idx2_a;
        logic [4:0] idx2_b;
        logic [4:0] out_a;
        logic [4:0] out_b;
    } operation;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SETTLE,
        ERR
    } state_t;

    state_t           state;
    operation         mem [DEPTH];
    operation         head;
    operation         op_reg;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             head_vld;
    logic             push;
    logic             pop;
    logic [TMR_W-1:0] timer;

    assign head     = mem[rd_ptr];
    assign in_ready = (level < LVL_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (state == IDLE) && head_vld && !flush;
    assign busy     = (state != IDLE) || (level != '0);
    assign cpu_op   = op_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= operation'(in_op);
        end
    end

    // Stage boundary: FIFO bookkeeping. head_vld qualifies the head one cycle after it lands,
    // so an op written at edge N is popped at edge N+2 and a popped slot is never re-read stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head_vld <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            head_vld <= !pop && (level != '0);
        end
    end

    // Stage boundary: issue FSM. NO_OP heads are popped in IDLE and silently discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_reg  <= '0;
            err     <= 1'b0;
            retired <= '0;
            timer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop && (head.mode != NO_OP)) begin
                        op_reg <= head;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A done seen here belongs to the previous op and is deliberately ignored.
                    op_reg.mode <= NO_OP;
                    timer       <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cpu_done) begin
                        state <= SETTLE;
                    end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                SETTLE: begin
                    retired <= retired + CNT_W'(1);
                    state   <= IDLE;
                end
                ERR: begin
                    if (clear_err) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
